// File: rtl/mux_arb_rr_pkg.sv
// Shared helpers for the arbitrating multiplexer: index-width calculation and
// a wrap-around first-set search used by the round-robin arbiter.
package mux_arb_rr_pkg;

  localparam int MAX_N    = 32;
  localparam int MAX_SELW = 5;

  typedef struct packed {
    logic                found;
    logic [MAX_N-1:0]    onehot;
    logic [MAX_SELW-1:0] idx;
  } pick_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'sd1 <<< k) < value) r = k + 1;
    end
    return r;
  endfunction

  // First set bit of req[0..n-1], searched upward from start with wrap at n.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input int n, input int start);
    pick_t p;
    int    i;
    p = '0;
    for (int k = 0; k < MAX_N; k++) begin
      i = start + k;
      if (i >= n) i = i - n;
      if ((k < n) && !p.found && req[i[MAX_SELW-1:0]]) begin
        p.found                     = 1'b1;
        p.onehot[i[MAX_SELW-1:0]]   = 1'b1;
        p.idx                       = i[MAX_SELW-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_arb_rr_if.sv
// Request/response bundle between N requesters and the shared output port.
interface mux_arb_rr_if
  import mux_arb_rr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               lock;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, lock, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, lock, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/mux_arb_rr_rr_arbiter.sv
// Combinational channel picker: round-robin from ptr, or fixed priority from 0.
module rr_arbiter
  import mux_arb_rr_pkg::*;
#(
  parameter int N    = 4,
  parameter int RR   = 1,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  // Widen the request vector and run the shared search.
  always_comb begin
    logic [MAX_N-1:0] req_ext_v;
    pick_t            pick_v;
    req_ext_v         = '0;
    req_ext_v[N-1:0]  = req;
    if (RR != 0) begin
      pick_v = rr_pick(req_ext_v, N, int'(ptr));
    end else begin
      pick_v = rr_pick(req_ext_v, N, 0);
    end
    gnt_onehot = pick_v.onehot[N-1:0];
    gnt_idx    = pick_v.idx[SELW-1:0];
    gnt_valid  = pick_v.found;
  end

endmodule

// File: rtl/mux_arb_rr.sv
// N-channel arbitrating multiplexer with a one-entry registered output stage
// and valid/ready handshakes on both sides.
module mux_arb_rr
  import mux_arb_rr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 1
) (
  input  logic         clk,
  input  logic         rst,
  mux_arb_rr_if.slave  bus
);

  localparam int SELW = clog2(N);

  logic [SELW-1:0]  ptr_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_sel_r;
  logic             out_valid_r;

  logic [N-1:0]     gnt_onehot_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic             gnt_valid_s;
  logic             free_s;
  logic             accept_s;

  rr_arbiter #(
    .N    (N),
    .RR   (RR),
    .SELW (SELW)
  ) u_arb (
    .req        (bus.in_valid),
    .ptr        (ptr_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_valid  (gnt_valid_s)
  );

  // Accept only when the output stage can take a beat and reset is released.
  always_comb begin
    free_s   = !out_valid_r || bus.out_ready;
    accept_s = free_s && gnt_valid_s && !rst;
  end

  assign bus.in_ready  = accept_s ? gnt_onehot_s : {N{1'b0}};
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.out_valid = out_valid_r;

  // Output register and arbitration pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= '0;
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.in_data[gnt_idx_s*WIDTH +: WIDTH];
        out_sel_r   <= gnt_idx_s;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      // Explicit wrap keeps ptr below N when N is not a power of two.
      if (accept_s && (RR != 0)) begin
        if (bus.lock) begin
          ptr_r <= gnt_idx_s;
        end else if (gnt_idx_s == SELW'(N - 1)) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= gnt_idx_s + SELW'(1);
        end
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

endmodule
